// File: rtl/pc_dual_fifo_scheduler.sv
// pc_dual_fifo_scheduler: ping-pong PC FIFOs (current/next character) feeding a regex CPU, with match FSM.
module pc_dual_fifo_scheduler #(
  parameter int PC_WIDTH = 8,
  parameter int FIFO_WIDTH_POWER_OF_2 = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           last_character,
  input  logic                           cpu_running,
  input  logic                           cpu_accepts,
  input  logic                           in_pc_valid,
  input  logic [PC_WIDTH-1:0]            in_pc,
  input  logic                           in_pc_is_directed_to_current,
  output logic                           in_pc_ready,
  output logic                           out_pc_valid,
  output logic [PC_WIDTH-1:0]            out_pc,
  input  logic                           out_pc_ready,
  output logic                           advance,
  output logic                           done,
  output logic                           accepted,
  output logic [FIFO_WIDTH_POWER_OF_2:0] latency
);
  localparam int AW = FIFO_WIDTH_POWER_OF_2;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] D = CW'(1 << AW);
  typedef enum logic [1:0] {IDLE, RUN, ADVANCE, DONE} state_t;
  state_t state, state_nx;
  logic sel;
  logic [PC_WIDTH-1:0] mem_a [1<<AW];
  logic [PC_WIDTH-1:0] mem_b [1<<AW];
  logic [AW-1:0] rd_a, wr_a, rd_b, wr_b;
  logic [CW-1:0] cnt_a, cnt_b, cur_cnt, nxt_cnt, tgt_cnt;
  logic tgt_b, push, pop, push_a, push_b, pop_a, pop_b, begin_match, swap;
  always_comb begin
    cur_cnt      = sel ? cnt_b : cnt_a;
    nxt_cnt      = sel ? cnt_a : cnt_b;
    tgt_b        = in_pc_is_directed_to_current ? sel : ~sel;
    tgt_cnt      = tgt_b ? cnt_b : cnt_a;
    in_pc_ready  = (state == RUN) && (tgt_cnt < D);
    out_pc_valid = (state == RUN) && (cur_cnt != '0);
    out_pc       = out_pc_valid ? (sel ? mem_b[rd_b] : mem_a[rd_a]) : '0;
    push         = in_pc_valid && in_pc_ready;
    pop          = out_pc_valid && out_pc_ready;
    push_a       = push && !tgt_b;
    push_b       = push && tgt_b;
    pop_a        = pop && !sel;
    pop_b        = pop && sel;
    begin_match  = ((state == IDLE) || (state == DONE)) && start;
    swap         = (state == ADVANCE) && !last_character && (nxt_cnt != '0);
    advance      = swap;
    done         = (state == DONE);
    latency      = cur_cnt;
  end
  // RUN only gives up the character once the CPU is idle and nothing is still being offered
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = start ? RUN : state;
      RUN:        state_nx = cpu_accepts ? DONE :
                             (cur_cnt == '0 && !cpu_running && !in_pc_valid) ? ADVANCE : RUN;
      ADVANCE:    state_nx = swap ? RUN : DONE;
      default:    state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      sel      <= 1'b0;
      accepted <= 1'b0;
      rd_a     <= '0;
      wr_a     <= '0;
      cnt_a    <= '0;
      rd_b     <= '0;
      wr_b     <= '0;
      cnt_b    <= '0;
    end else begin
      state <= state_nx;
      if (begin_match) begin
        sel      <= 1'b0;
        accepted <= 1'b0;
        rd_a     <= '0;
        wr_a     <= AW'(1);
        cnt_a    <= CW'(1);
        rd_b     <= '0;
        wr_b     <= '0;
        cnt_b    <= '0;
      end else begin
        if (swap) sel <= ~sel;
        if (state == RUN && cpu_accepts) accepted <= 1'b1;
        if (push_a) wr_a <= wr_a + 1'b1;
        if (pop_a) rd_a <= rd_a + 1'b1;
        if (push_b) wr_b <= wr_b + 1'b1;
        if (pop_b) rd_b <= rd_b + 1'b1;
        cnt_a <= cnt_a + CW'(push_a) - CW'(pop_a);
        cnt_b <= cnt_b + CW'(push_b) - CW'(pop_b);
      end
    end
  end
  // storage needs no reset: counts gate every read
  always_ff @(posedge clk) begin
    if (begin_match) mem_a['0] <= '0;
    else if (push_a) mem_a[wr_a] <= in_pc;
    if (push_b) mem_b[wr_b] <= in_pc;
  end
endmodule

// File: tb/tb_pc_dual_fifo_scheduler.sv
// tb_pc_dual_fifo_scheduler: directed scenarios plus randomized run against a queue-based reference model.
module tb_pc_dual_fifo_scheduler;
  localparam int PW = 8;
  localparam int AW = 2;
  localparam int D = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_ADV = 2, M_DONE = 3;
  logic clk = 1'b0;
  logic rst, start, last_character, cpu_running, cpu_accepts, in_pc_valid, in_dir, out_pc_ready;
  logic [PW-1:0] in_pc, out_pc;
  logic in_pc_ready, out_pc_valid, advance, done, accepted;
  logic [AW:0] latency;
  int checks = 0;
  int errors = 0;
  logic [PW-1:0] q0[$];
  logic [PW-1:0] q1[$];
  int cur, mode;
  bit macc;
  bit e_ready, e_valid, e_adv, e_done, e_acc;
  logic [PW-1:0] e_out;
  int e_lat;

  pc_dual_fifo_scheduler #(.PC_WIDTH(PW), .FIFO_WIDTH_POWER_OF_2(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .last_character(last_character),
    .cpu_running(cpu_running), .cpu_accepts(cpu_accepts), .in_pc_valid(in_pc_valid),
    .in_pc(in_pc), .in_pc_is_directed_to_current(in_dir), .in_pc_ready(in_pc_ready),
    .out_pc_valid(out_pc_valid), .out_pc(out_pc), .out_pc_ready(out_pc_ready),
    .advance(advance), .done(done), .accepted(accepted), .latency(latency)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int qs(int i);
    return i != 0 ? q1.size() : q0.size();
  endfunction

  function automatic logic [PW-1:0] qh(int i);
    return i != 0 ? q1[0] : q0[0];
  endfunction

  task automatic model_clear();
    q0.delete();
    q1.delete();
    cur = 0;
    mode = M_IDLE;
    macc = 1'b0;
  endtask

  task automatic model_expect();
    int t;
    t = in_dir ? cur : 1 - cur;
    e_ready = (mode == M_RUN) && (qs(t) < D);
    e_valid = (mode == M_RUN) && (qs(cur) > 0);
    e_out = e_valid ? qh(cur) : '0;
    e_adv = (mode == M_ADV) && !last_character && (qs(1 - cur) > 0);
    e_done = (mode == M_DONE);
    e_acc = macc;
    e_lat = qs(cur);
  endtask

  task automatic model_step();
    int c0, n0, t;
    c0 = qs(cur);
    n0 = qs(1 - cur);
    t = in_dir ? cur : 1 - cur;
    model_expect();
    if (!rst) begin
      model_clear();
      return;
    end
    case (mode)
      M_IDLE, M_DONE: if (start) begin
        model_clear();
        q0.push_back(8'd0);
        mode = M_RUN;
      end
      M_RUN: begin
        if (e_valid && out_pc_ready) begin
          if (cur != 0) void'(q1.pop_front());
          else void'(q0.pop_front());
        end
        if (in_pc_valid && e_ready) begin
          if (t != 0) q1.push_back(in_pc);
          else q0.push_back(in_pc);
        end
        if (cpu_accepts) begin
          mode = M_DONE;
          macc = 1'b1;
        end else if (c0 == 0 && !cpu_running && !in_pc_valid) mode = M_ADV;
      end
      default: if (last_character || n0 == 0) mode = M_DONE;
               else begin
                 cur = 1 - cur;
                 mode = M_RUN;
               end
    endcase
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    start = 0; last_character = 0; cpu_running = 0; cpu_accepts = 0;
    in_pc_valid = 0; in_pc = '0; in_dir = 0; out_pc_ready = 0;
  endtask

  task automatic do_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic end_match();
    in_pc_valid = 0;
    cpu_accepts = 1;
    tick();
    cpu_accepts = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    idle_inputs();
    model_clear();
    #1;
    checks++;
    if ({in_pc_ready, out_pc_valid, out_pc, advance, done, accepted, latency} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {in_pc_ready, out_pc_valid, out_pc, advance, done, accepted, latency});
    end
    tick();
    tick();
    rst = 1;
  endtask

  task automatic test_start();
    idle_inputs();
    cpu_running = 1;
    out_pc_ready = 1;
    do_start();
    #1;
    checks++;
    if (out_pc_valid !== 1'b1) begin errors++; $display("FAIL start_valid: got %b expected 1", out_pc_valid); end
    checks++;
    if (out_pc !== 8'd0) begin errors++; $display("FAIL start_pc: got %0d expected 0", out_pc); end
    checks++;
    if (latency !== 3'd1) begin errors++; $display("FAIL start_latency: got %0d expected 1", latency); end
    tick();
    #1;
    checks++;
    if (latency !== 3'd0) begin errors++; $display("FAIL start_drained: got %0d expected 0", latency); end
    end_match();
  endtask

  task automatic test_full();
    idle_inputs();
    cpu_running = 1;
    out_pc_ready = 1;
    do_start();
    tick();
    out_pc_ready = 0;
    for (int i = 3; i <= 6; i++) begin
      in_pc_valid = 1;
      in_pc = PW'(i);
      in_dir = 1;
      #1;
      checks++;
      if (in_pc_ready !== 1'b1) begin errors++; $display("FAIL full_push%0d: ready got %b expected 1", i, in_pc_ready); end
      tick();
    end
    in_pc = 8'd7;
    #1;
    checks++;
    if (in_pc_ready !== 1'b0) begin errors++; $display("FAIL full_refuse: ready got %b expected 0", in_pc_ready); end
    checks++;
    if (latency !== 3'd4) begin errors++; $display("FAIL full_latency: got %0d expected 4", latency); end
    tick();
    #1;
    checks++;
    if (out_pc !== 8'd3 || out_pc_valid !== 1'b1) begin
      errors++; $display("FAIL full_hold: got valid=%b pc=%0d expected valid=1 pc=3", out_pc_valid, out_pc);
    end
    out_pc_ready = 1;
    #1;
    checks++;
    if (in_pc_ready !== 1'b0) begin errors++; $display("FAIL full_refuse_on_pop: ready got %b expected 0", in_pc_ready); end
    checks++;
    if (out_pc !== 8'd3) begin errors++; $display("FAIL full_head: got %0d expected 3", out_pc); end
    tick();
    in_pc_valid = 0;
    out_pc_ready = 0;
    #1;
    checks++;
    if (latency !== 3'd3 || out_pc !== 8'd4) begin
      errors++; $display("FAIL full_after_pop: got lat=%0d pc=%0d expected lat=3 pc=4", latency, out_pc);
    end
    end_match();
  endtask

  task automatic test_advance();
    idle_inputs();
    cpu_running = 1;
    out_pc_ready = 1;
    do_start();
    in_pc_valid = 1;
    in_pc = 8'd9;
    in_dir = 0;
    #1;
    checks++;
    if (in_pc_ready !== 1'b1) begin errors++; $display("FAIL adv_push_next: ready got %b expected 1", in_pc_ready); end
    tick();
    in_pc_valid = 0;
    out_pc_ready = 0;
    cpu_running = 0;
    #1;
    checks++;
    if (advance !== 1'b0) begin errors++; $display("FAIL adv_early: got %b expected 0", advance); end
    tick();
    cpu_running = 1;
    #1;
    checks++;
    if (advance !== 1'b1) begin errors++; $display("FAIL adv_pulse: got %b expected 1", advance); end
    tick();
    #1;
    checks++;
    if (advance !== 1'b0) begin errors++; $display("FAIL adv_single: got %b expected 0", advance); end
    checks++;
    if (out_pc_valid !== 1'b1 || out_pc !== 8'd9 || latency !== 3'd1) begin
      errors++;
      $display("FAIL adv_new_pc: got valid=%b pc=%0d lat=%0d expected valid=1 pc=9 lat=1", out_pc_valid, out_pc, latency);
    end
    end_match();
  endtask

  task automatic test_done_empty();
    int pulses;
    pulses = 0;
    idle_inputs();
    out_pc_ready = 1;
    do_start();
    for (int k = 0; k < 6; k++) begin
      #1;
      if (advance) pulses++;
      tick();
    end
    #1;
    checks++;
    if (done !== 1'b1 || accepted !== 1'b0) begin
      errors++; $display("FAIL empty_done: got done=%b acc=%b expected done=1 acc=0", done, accepted);
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL empty_no_advance: got %0d pulses expected 0", pulses); end
  endtask

  task automatic test_accept();
    idle_inputs();
    cpu_running = 1;
    do_start();
    in_pc_valid = 1;
    in_pc = 8'd1;
    in_dir = 1;
    tick();
    in_pc = 8'd2;
    in_dir = 0;
    tick();
    in_pc_valid = 0;
    cpu_accepts = 1;
    #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL accept_early: done got %b expected 0", done); end
    tick();
    cpu_accepts = 0;
    for (int k = 0; k < 3; k++) begin
      in_pc_valid = 1;
      in_dir = k[0];
      #1;
      checks++;
      if (done !== 1'b1 || accepted !== 1'b1) begin
        errors++; $display("FAIL accept_flags%0d: got done=%b acc=%b expected 1 1", k, done, accepted);
      end
      checks++;
      if (in_pc_ready !== 1'b0 || out_pc_valid !== 1'b0) begin
        errors++; $display("FAIL accept_closed%0d: got ready=%b valid=%b expected 0 0", k, in_pc_ready, out_pc_valid);
      end
      tick();
    end
    in_pc_valid = 0;
  endtask

  task automatic test_async_reset();
    idle_inputs();
    cpu_running = 1;
    do_start();
    in_pc_valid = 1;
    in_dir = 1;
    in_pc = 8'd1;
    tick();
    in_pc = 8'd2;
    tick();
    in_pc_valid = 0;
    #1;
    checks++;
    if (latency !== 3'd3) begin errors++; $display("FAIL areset_queued: got %0d expected 3", latency); end
    rst = 0;
    model_clear();
    #1;
    checks++;
    if ({in_pc_ready, out_pc_valid, out_pc, advance, done, accepted, latency} !== '0) begin
      errors++;
      $display("FAIL areset_outputs: got %b expected all zero",
               {in_pc_ready, out_pc_valid, out_pc, advance, done, accepted, latency});
    end
    tick();
    rst = 1;
    do_start();
    #1;
    checks++;
    if (out_pc_valid !== 1'b1 || out_pc !== 8'd0 || latency !== 3'd1) begin
      errors++;
      $display("FAIL areset_restart: got valid=%b pc=%0d lat=%0d expected 1 0 1", out_pc_valid, out_pc, latency);
    end
    out_pc_ready = 1;
    tick();
    #1;
    checks++;
    if (out_pc_valid !== 1'b0 || latency !== 3'd0) begin
      errors++; $display("FAIL areset_stale: got valid=%b lat=%0d expected 0 0", out_pc_valid, latency);
    end
    end_match();
  endtask

  task automatic test_random();
    idle_inputs();
    for (int n = 0; n < 800; n++) begin
      start = (mode == M_IDLE || mode == M_DONE) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      last_character = ($urandom_range(0, 3) == 0);
      cpu_running = $urandom_range(0, 1) == 1;
      cpu_accepts = ($urandom_range(0, 39) == 0);
      in_pc_valid = ($urandom_range(0, 9) < 6);
      in_pc = PW'($urandom);
      in_dir = $urandom_range(0, 1) == 1;
      out_pc_ready = ($urandom_range(0, 3) != 0);
      #1;
      model_expect();
      checks++;
      if (in_pc_ready !== e_ready) begin errors++; $display("FAIL rnd_ready @%0d: got %b expected %b", n, in_pc_ready, e_ready); end
      checks++;
      if (out_pc_valid !== e_valid) begin errors++; $display("FAIL rnd_valid @%0d: got %b expected %b", n, out_pc_valid, e_valid); end
      checks++;
      if (out_pc !== e_out) begin errors++; $display("FAIL rnd_pc @%0d: got %0d expected %0d", n, out_pc, e_out); end
      checks++;
      if (advance !== e_adv) begin errors++; $display("FAIL rnd_advance @%0d: got %b expected %b", n, advance, e_adv); end
      checks++;
      if (done !== e_done) begin errors++; $display("FAIL rnd_done @%0d: got %b expected %b", n, done, e_done); end
      checks++;
      if (accepted !== e_acc) begin errors++; $display("FAIL rnd_accepted @%0d: got %b expected %b", n, accepted, e_acc); end
      checks++;
      if (int'(latency) != e_lat) begin errors++; $display("FAIL rnd_latency @%0d: got %0d expected %0d", n, latency, e_lat); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_full();
    test_advance();
    test_done_empty();
    test_accept();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
